// File: rtl/audio_playback_fifo.sv
// Byte-wide slave front end feeding a sample FIFO that drains to the codec DAC
// on each rising edge of the audio driver's advance strobe.
module audio_playback_fifo #(
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned LVL_W        = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              writedata,
  input  logic                    write,
  input  logic                    chipselect,
  input  logic [15:0]             address,
  output logic [7:0]              readdata,
  input  logic                    advance,
  output logic [SAMPLE_WIDTH-1:0] dac_left,
  output logic [SAMPLE_WIDTH-1:0] dac_right,
  output logic [LVL_W-1:0]        level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [SAMPLE_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [LVL_W-1:0]        r_level;
  logic [7:0]              r_stage_lo;
  logic [7:0]              r_stage_hi;
  logic                    r_enable;
  logic                    r_overflow;
  logic                    r_underrun;
  logic                    r_adv_q;
  logic [SAMPLE_WIDTH-1:0] r_dac;

  logic                    w_wr_en;
  logic                    w_commit;
  logic                    w_ctrl;
  logic                    w_clear;
  logic                    w_pop_evt;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic [SAMPLE_WIDTH-1:0] w_word;
  logic [15:0]             w_level16;

  assign w_wr_en   = chipselect & write;
  assign w_commit  = w_wr_en & (address == 16'd2);
  assign w_ctrl    = w_wr_en & (address == 16'd3);
  assign w_clear   = w_ctrl & writedata[1];
  assign w_pop_evt = advance & ~r_adv_q;
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVL_W'(DEPTH));
  // Clear wins over any pointer movement; a same-edge pop still lets a commit into a full FIFO.
  assign w_pop     = w_pop_evt & r_enable & ~w_empty & ~w_clear;
  assign w_push    = w_commit & (~w_full | w_pop);
  assign w_word    = SAMPLE_WIDTH'({writedata, r_stage_hi, r_stage_lo});
  assign w_level16 = 16'(r_level);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  // Pointers, level, staging bytes and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_stage_lo <= '0;
      r_stage_hi <= '0;
      r_enable   <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
      r_adv_q    <= 1'b0;
    end else begin
      r_adv_q <= advance;
      if (w_ctrl) r_enable <= writedata[0];
      if (w_clear) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_level    <= '0;
        r_stage_lo <= '0;
        r_stage_hi <= '0;
        r_overflow <= 1'b0;
        r_underrun <= 1'b0;
      end else begin
        if (w_wr_en && address == 16'd0) r_stage_lo <= writedata;
        if (w_wr_en && address == 16'd1) r_stage_hi <= writedata;
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_commit && !w_push) r_overflow <= 1'b1;
        if (w_pop_evt && r_enable && w_empty) r_underrun <= 1'b1;
        r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      end
    end
  end

  // DAC register: updated only on an advance edge, zero when disabled or starved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dac <= '0;
    end else if (w_pop_evt) begin
      if (r_enable && !w_empty) r_dac <= r_mem[r_rd_ptr];
      else                      r_dac <= '0;
    end
  end

  always_comb begin
    readdata = 8'h00;
    case (address)
      16'd0:   readdata = w_level16[7:0];
      16'd1:   readdata = w_level16[15:8];
      16'd2:   readdata = {3'b000, r_enable, r_underrun, r_overflow, w_full, w_empty};
      16'd3:   readdata = {7'b0000000, r_enable};
      default: readdata = 8'h00;
    endcase
  end

  assign dac_left  = r_dac;
  assign dac_right = r_dac;
  assign level     = r_level;

endmodule

// File: doc/audio_playback_fifo.md
Name: audio_playback_fifo

Overview:
- Software-to-codec playback path: the write-direction counterpart of the accelerator's byte-wide read-only register window.
- Accepts 24-bit samples written one byte at a time over the same 8-bit Avalon-style slave interface and buffers them in a FIFO.
- Pops one sample per audio-driver `advance` strobe and drives it onto the codec DAC left/right inputs.
- Exposes fill level and sticky status flags for software polling.

Parameters:
- DEPTH, 512: FIFO depth in samples. Must be a power of 2, 4..32768.
- SAMPLE_WIDTH, 24: DAC sample width. Fixed at 24; the register map assumes 3 bytes.
- LVL_W, $clog2(DEPTH)+1: width of the fill-level counter.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- writedata  in  8  write byte
- write  in  1  write strobe, qualified by chipselect
- chipselect  in  1  slave select
- address  in  16  byte address
- readdata  out  8  status byte; combinational from address
- advance  in  1  sample strobe from the audio driver; level, asynchronous relative to sampling edge
- dac_left  out  24  playback sample, left
- dac_right  out  24  playback sample, right; always equal to dac_left (mono)
- level  out  LVL_W  current FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, level, staging bytes, enable, overflow and underrun cleared.
  - dac_left = dac_right = 0; adv_q = 0.
  - FIFO contents undefined.
- Write acceptance: a write takes effect only when chipselect=1 and write=1 at the clk edge. Software byte order is little-endian, so no byte swap is needed.
  - addr 0: stage[7:0] <= writedata.
  - addr 1: stage[15:8] <= writedata.
  - addr 2: commit. The word {writedata, stage[15:8], stage[7:0]} is pushed. Staging bytes are retained, so repeated commits reuse the low bytes.
  - addr 3: control.
    - bit0 = enable, stored.
    - bit1 = clear, self-clearing and not stored. Clear flushes the FIFO (level 0, pointers 0), clears overflow and underrun, and zeroes the staging bytes. It does not change dac outputs.
  - Other addresses: ignored.
- Read map (address[15:0] decoded in full):
  - 0: level[7:0].
  - 1: level[LVL_W-1:8], zero-extended.
  - 2: {3'b0, enable, underrun, overflow, full, empty}.
  - 3: {7'b0, enable}.
  - All other addresses: 0.
- Advance detection: adv_q <= advance every clk.
  - pop_evt = advance & ~adv_q, evaluated combinationally before the edge.
  - Exactly one pop_evt per advance rising edge, regardless of how long advance stays high.
- Playback, at a clk edge with pop_evt=1 (all conditions use pre-edge state):
  - enable=0: dac outputs <= 0. No pop, no flag change.
  - enable=1, empty: dac outputs <= 0; underrun <= 1.
  - enable=1, not empty: dac outputs <= mem[rd_ptr]; rd_ptr++; level--.
  - dac outputs are otherwise held. New values are visible the cycle after the pop edge.
- Push rules, at a commit edge:
  - Accepted if pre-edge level < DEPTH, or if a pop occurs on the same edge. An accepted push writes mem[wr_ptr] and does wr_ptr++.
  - Rejected otherwise: data dropped, overflow <= 1.
- Simultaneous push and pop: both occur and level is unchanged. A push into an empty FIFO cannot satisfy a same-edge pop; that case is an underrun, and the push is still accepted.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full = (level == DEPTH); empty = (level == 0).
- Clear priority:
  - Clear has priority over a same-edge pop and over any FIFO state change.
  - A same-edge pop_evt still zeroes/updates dac outputs per the enable rules, but does not move pointers and does not set underrun.
  - Enable is written from bit0 on the same control write.
- Sticky flags: overflow and underrun stay set until clear or reset.
- Reset mid-operation: asynchronous return to reset state. No partial push or pop may survive.
- Implementation: the memory is a simple dual-port array, one write port and one read port.

Test Plan:
- After reset, read addr 0..3 -> 0x00, 0x00, 0x01 (empty), 0x00; dac_left = 0.
- Write addr3=0x01, then bytes 0x56, 0x34, 0x12 to addr 0,1,2; pulse advance high for 10 clk -> level 1 then 0; dac_left = dac_right = 0x123456 exactly one cycle after the first advance-high sample; only one pop.
- Commit DEPTH+1 samples with enable=0 -> level = DEPTH, full=1, overflow=1; the readback at addr2 is 0x06.
- With level=DEPTH, commit on the same edge as pop_evt -> push accepted; level stays DEPTH; overflow unchanged.
- enable=1 with FIFO empty, one advance -> dac outputs 0; status bit3 (underrun) = 1. Then write addr3=0x03 -> flags clear, level 0, enable stays 1.
- Fill 5 samples, assert reset for 1 clk mid-stream with advance toggling -> level 0; dac = 0; enable 0; the next advance produces no pop.
